// File: rtl/router_fsm_nch_if.sv
// rtl/router_fsm_nch_if.sv - packet-control handshake bundle between router blocks and the FSM
interface router_fsm_nch_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    // Source / register-block / FIFO-bank side
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic              parity_done;
    logic              low_pkt_valid;
    logic              fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_reset;

    // Controller side
    logic              busy;
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              full_state;
    logic              laf_state;
    logic              write_enb_reg;
    logic              rst_int_reg;
    logic              drop_state;
    logic [ADDR_W-1:0] dest_addr;
    logic              wait_timeout;
    logic [7:0]        drop_cnt;

    modport master (
        output pkt_valid, data_in, parity_done, low_pkt_valid,
               fifo_full, fifo_empty, soft_reset,
        input  busy, detect_add, lfd_state, ld_state, full_state, laf_state,
               write_enb_reg, rst_int_reg, drop_state, dest_addr,
               wait_timeout, drop_cnt
    );

    modport slave (
        input  pkt_valid, data_in, parity_done, low_pkt_valid,
               fifo_full, fifo_empty, soft_reset,
        output busy, detect_add, lfd_state, ld_state, full_state, laf_state,
               write_enb_reg, rst_int_reg, drop_state, dest_addr,
               wait_timeout, drop_cnt
    );
endinterface

// File: rtl/router_fsm_nch.sv
// rtl/router_fsm_nch.sv - N-channel router packet-control FSM with drop and bounded destination wait
module router_fsm_nch #(
    parameter int NUM_CH   = 3,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 8,
    parameter int WAIT_MAX = 64
) (
    input  logic           clock,
    input  logic           resetn,
    router_fsm_nch_if.slave bus
);

    localparam int NUM_SLOTS = 2 ** ADDR_W;
    localparam int WAIT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
    localparam logic [ADDR_W:0]   NUM_CH_W  = (ADDR_W + 1)'(NUM_CH);

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        FIFO_FULL_STATE    = 4'd3,
        LOAD_AFTER_FULL    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [ADDR_W-1:0]    dest_addr_q;
    logic [ADDR_W-1:0]    hdr_addr;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [7:0]           drop_cnt_q;
    logic                 wait_timeout_q;
    logic [NUM_SLOTS-1:0] empty_pad;
    logic [NUM_SLOTS-1:0] soft_pad;
    logic                 hdr_in_range;
    logic                 timeout_hit;
    logic                 enter_drop;
    logic                 unused_data_bits;

    // Only the address field of data_in steers the FSM; payload bits pass through the register block.
    assign unused_data_bits = ^bus.data_in;

    assign hdr_addr     = bus.data_in[ADDR_W-1:0];
    assign hdr_in_range = {1'b0, hdr_addr} < NUM_CH_W;
    assign timeout_hit  = (WAIT_MAX != 0) && (wait_cnt == WAIT_LAST);
    assign enter_drop   = (next_state == DROP_PACKET) && (state != DROP_PACKET);

    // Widen per-channel flags to the full address space; missing channels read as not-empty / no reset.
    always_comb begin
        empty_pad                = '0;
        soft_pad                 = '0;
        empty_pad[NUM_CH-1:0]    = bus.fifo_empty;
        soft_pad[NUM_CH-1:0]     = bus.soft_reset;
    end

    // Next-state selection; a soft reset on the latched channel overrides everything.
    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    if (!hdr_in_range) begin
                        next_state = DROP_PACKET;
                    end else if (empty_pad[hdr_addr]) begin
                        next_state = LOAD_FIRST_DATA;
                    end else begin
                        next_state = WAIT_TILL_EMPTY;
                    end
                end
            end
            LOAD_FIRST_DATA: begin
                next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (bus.fifo_full) begin
                    next_state = FIFO_FULL_STATE;
                end else if (!bus.pkt_valid) begin
                    next_state = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) begin
                    next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done) begin
                    next_state = DECODE_ADDRESS;
                end else if (bus.low_pkt_valid) begin
                    next_state = LOAD_PARITY;
                end else begin
                    next_state = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                next_state = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                if (bus.fifo_full) begin
                    next_state = FIFO_FULL_STATE;
                end else begin
                    next_state = DECODE_ADDRESS;
                end
            end
            WAIT_TILL_EMPTY: begin
                // The destination emptying takes priority over an expiring wait.
                if (empty_pad[dest_addr_q]) begin
                    next_state = LOAD_FIRST_DATA;
                end else if (timeout_hit) begin
                    next_state = DROP_PACKET;
                end
            end
            DROP_PACKET: begin
                // pkt_valid low marks the parity byte, which is swallowed this cycle.
                if (!bus.pkt_valid) begin
                    next_state = DECODE_ADDRESS;
                end
            end
            default: begin
                next_state = DECODE_ADDRESS;
            end
        endcase
        if (soft_pad[dest_addr_q]) begin
            next_state = DECODE_ADDRESS;
        end
    end

    // State register and destination latch; the address tracks data_in while decoding.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= DECODE_ADDRESS;
            dest_addr_q <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS) begin
                dest_addr_q <= hdr_addr;
            end
        end
    end

    // Cycles spent waiting on a busy destination FIFO.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (state == WAIT_TILL_EMPTY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Saturating dropped-packet count and the timeout flag shown on the first drop cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            drop_cnt_q     <= '0;
            wait_timeout_q <= 1'b0;
        end else begin
            if (enter_drop && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            wait_timeout_q <= (state == WAIT_TILL_EMPTY) && (next_state == DROP_PACKET);
        end
    end

    // Moore decodes of the present state.
    always_comb begin
        bus.busy          = 1'b0;
        bus.detect_add    = 1'b0;
        bus.lfd_state     = 1'b0;
        bus.ld_state      = 1'b0;
        bus.full_state    = 1'b0;
        bus.laf_state     = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.rst_int_reg   = 1'b0;
        bus.drop_state    = 1'b0;
        case (state)
            DECODE_ADDRESS: begin
                bus.detect_add = 1'b1;
            end
            LOAD_FIRST_DATA: begin
                bus.busy      = 1'b1;
                bus.lfd_state = 1'b1;
            end
            LOAD_DATA: begin
                bus.ld_state      = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                bus.busy       = 1'b1;
                bus.full_state = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                bus.busy          = 1'b1;
                bus.laf_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                bus.busy          = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                bus.busy        = 1'b1;
                bus.rst_int_reg = 1'b1;
            end
            WAIT_TILL_EMPTY: begin
                bus.busy = 1'b1;
            end
            DROP_PACKET: begin
                // Source keeps streaming so the unwanted packet drains away.
                bus.drop_state = 1'b1;
            end
            default: begin
                bus.detect_add = 1'b0;
            end
        endcase
    end

    assign bus.dest_addr    = dest_addr_q;
    assign bus.wait_timeout = wait_timeout_q;
    assign bus.drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_router_fsm_nch.sv
// tb/tb_router_fsm_nch.sv - scoreboard bench for router_fsm_nch with transaction-level packet model
module tb_router_fsm_nch;

    localparam int NUM_CH   = 3;
    localparam int ADDR_W   = 2;
    localparam int DATA_W   = 8;
    localparam int WAIT_MAX = 8;

    localparam int P_DEC  = 0;
    localparam int P_LFD  = 1;
    localparam int P_LD   = 2;
    localparam int P_FULL = 3;
    localparam int P_LAF  = 4;
    localparam int P_LP   = 5;
    localparam int P_CPE  = 6;
    localparam int P_WAIT = 7;
    localparam int P_DROP = 8;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    always #5 clock = ~clock;

    router_fsm_nch_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    router_fsm_nch #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .bus(bus)
    );

    typedef struct {
        int                ph;
        bit                to;
        logic [ADDR_W-1:0] dest;
        logic [7:0]        drop;
        string             nm;
    } exp_t;

    exp_t              sb[$];
    exp_t              mon_e;
    logic [8:0]        mon_act;
    int                checks = 0;
    int                errors = 0;
    int                cur    = P_DEC;
    logic [ADDR_W-1:0] m_dest = '0;
    int                m_drop = 0;

    // {busy, detect_add, lfd, ld, full, laf, write_enb, rst_int, drop} for each phase
    function automatic logic [8:0] decodes(input int ph);
        case (ph)
            P_DEC:   return 9'b010000000;
            P_LFD:   return 9'b101000000;
            P_LD:    return 9'b000100100;
            P_FULL:  return 9'b100010000;
            P_LAF:   return 9'b100001100;
            P_LP:    return 9'b100000100;
            P_CPE:   return 9'b100000010;
            P_WAIT:  return 9'b100000000;
            P_DROP:  return 9'b000000001;
            default: return 9'h1FF;
        endcase
    endfunction

    function automatic logic [7:0] r8();
        return 8'($urandom);
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    function automatic logic [2:0] r3();
        return 3'($urandom);
    endfunction

    // Random soft_reset that never hits the packet's own channel.
    function automatic logic [2:0] r3x(input int addr);
        logic [2:0] m;
        m = 3'($urandom);
        if (addr < NUM_CH) m[2'(addr)] = 1'b0;
        return m;
    endfunction

    // Drive one cycle and queue the outputs expected after the following edge.
    task automatic step(input bit rst_n, input bit pv, input logic [7:0] din, input bit pd,
                        input bit lpv, input bit ff, input logic [2:0] fe, input logic [2:0] sr,
                        input int nxt, input string nm);
        exp_t e;
        @(negedge clock);
        resetn            = rst_n;
        bus.pkt_valid     = pv;
        bus.data_in       = din;
        bus.parity_done   = pd;
        bus.low_pkt_valid = lpv;
        bus.fifo_full     = ff;
        bus.fifo_empty    = fe;
        bus.soft_reset    = sr;
        if (!rst_n) begin
            nxt    = P_DEC;
            m_dest = '0;
            m_drop = 0;
            e.to   = 1'b0;
        end else begin
            e.to = (cur == P_WAIT) && (nxt == P_DROP);
            if (cur == P_DEC) m_dest = din[ADDR_W-1:0];
            if (nxt == P_DROP && cur != P_DROP && m_drop < 255) m_drop++;
        end
        e.ph   = nxt;
        e.dest = m_dest;
        e.drop = 8'(m_drop);
        e.nm   = nm;
        sb.push_back(e);
        cur = nxt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, r8(), rb(), rb(), rb(), r3(), r3(), P_DEC, "idle");
    endtask

    task automatic header(input logic [7:0] hdr, input bit empty, input int nxt, input string nm);
        logic [2:0] fe;
        int addr;
        addr = int'(hdr[ADDR_W-1:0]);
        fe = r3();
        if (addr < NUM_CH) fe[2'(addr)] = empty;
        step(1, 1, hdr, rb(), rb(), rb(), fe, 3'b000, nxt, nm);
    endtask

    task automatic drop_body(input int addr, input int len);
        for (int k = 0; k < len; k++) step(1, 1, r8(), rb(), rb(), rb(), r3(), r3x(addr), P_DROP, "drop_byte");
        step(1, 0, r8(), rb(), rb(), rb(), r3(), r3x(addr), P_DEC, "drop_parity");
    endtask

    // Payload path from LOAD_FIRST_DATA: len bytes with pkt_valid high, then parity with it low.
    task automatic body(input int addr, input int len, input int full_pos, input int full_len,
                        input int laf_mode, input int cpe_full, input int soft_pos);
        bit done;
        bit to_lp;
        done  = 1'b0;
        to_lp = 1'b0;
        step(1, 1, r8(), rb(), rb(), rb(), r3(), r3x(addr), P_LD, "lfd");
        for (int k = 1; k <= len && !done; k++) begin
            if (k == soft_pos) begin
                step(1, 1, r8(), 0, 0, 0, r3(), r3x(addr) | (3'b001 << addr), P_DEC, "soft_rst");
                done = 1'b1;
            end else if (k == full_pos) begin
                step(1, 1, r8(), 0, 0, 1, r3(), r3x(addr), P_FULL, "ld_full");
                for (int j = 1; j < full_len; j++)
                    step(1, 1, r8(), rb(), rb(), 1, r3(), r3x(addr), P_FULL, "full_hold");
                step(1, 1, r8(), rb(), rb(), 0, r3(), r3x(addr), P_LAF, "full_clear");
                if (laf_mode == 0) begin
                    step(1, 1, r8(), 0, 0, rb(), r3(), r3x(addr), P_LD, "laf_resume");
                end else if (laf_mode == 1) begin
                    step(1, 0, r8(), 0, 1, rb(), r3(), r3x(addr), P_LP, "laf_low_pv");
                    to_lp = 1'b1;
                    done  = 1'b1;
                end else begin
                    step(1, 0, r8(), 1, rb(), rb(), r3(), r3x(addr), P_DEC, "laf_parity_done");
                    done = 1'b1;
                end
            end else begin
                bit pv = (k < len);
                step(1, pv, r8(), 0, 0, 0, r3(), r3x(addr), pv ? P_LD : P_LP, pv ? "ld" : "ld_parity");
                if (!pv) to_lp = 1'b1;
            end
        end
        if (to_lp) begin
            step(1, 0, r8(), rb(), rb(), rb(), r3(), r3x(addr), P_CPE, "lp");
            if (cpe_full > 0) begin
                step(1, 0, r8(), 0, 0, 1, r3(), r3x(addr), P_FULL, "cpe_full");
                for (int j = 1; j < cpe_full; j++)
                    step(1, 0, r8(), rb(), rb(), 1, r3(), r3x(addr), P_FULL, "cpe_full_hold");
                step(1, 0, r8(), rb(), rb(), 0, r3(), r3x(addr), P_LAF, "cpe_full_clear");
                step(1, 0, r8(), 1, rb(), rb(), r3(), r3x(addr), P_DEC, "cpe_laf_done");
            end else begin
                step(1, 0, r8(), rb(), rb(), 0, r3(), r3x(addr), P_DEC, "cpe");
            end
        end
    endtask

    // One packet; empty_at: -1 destination already empty, 0 never empties, k empties in wait cycle k.
    task automatic pkt(input logic [7:0] hdr, input int len, input int empty_at, input int full_pos,
                       input int full_len, input int laf_mode, input int cpe_full, input int soft_pos);
        int addr;
        bit got;
        addr = int'(hdr[ADDR_W-1:0]);
        if (addr >= NUM_CH) begin
            header(hdr, rb(), P_DROP, "hdr_bad_addr");
            drop_body(addr, len);
        end else if (empty_at < 0) begin
            header(hdr, 1'b1, P_LFD, "hdr");
            body(addr, len, full_pos, full_len, laf_mode, cpe_full, soft_pos);
        end else begin
            header(hdr, 1'b0, P_WAIT, "hdr_dest_busy");
            got = 1'b0;
            for (int j = 1; j <= WAIT_MAX && !got; j++) begin
                logic [2:0] fe;
                fe = r3();
                fe[2'(addr)] = (j == empty_at);
                if (j == empty_at) begin
                    step(1, 1, r8(), rb(), rb(), rb(), fe, r3x(addr), P_LFD, "wait_empty");
                    got = 1'b1;
                end else begin
                    step(1, 1, r8(), rb(), rb(), rb(), fe, r3x(addr),
                         (j == WAIT_MAX) ? P_DROP : P_WAIT, (j == WAIT_MAX) ? "wait_expire" : "wait");
                end
            end
            if (got) body(addr, len, full_pos, full_len, laf_mode, cpe_full, soft_pos);
            else     drop_body(addr, len);
        end
    endtask

    // Monitor: compare every queued expectation just after the edge it refers to.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                mon_e   = sb.pop_front();
                mon_act = {bus.busy, bus.detect_add, bus.lfd_state, bus.ld_state, bus.full_state,
                           bus.laf_state, bus.write_enb_reg, bus.rst_int_reg, bus.drop_state};
                checks++;
                if (mon_act !== decodes(mon_e.ph) || bus.wait_timeout !== mon_e.to ||
                    bus.dest_addr !== mon_e.dest || bus.drop_cnt !== mon_e.drop) begin
                    errors++;
                    $display("FAIL %s @%0t: decodes=%b timeout=%b dest=%0d drop_cnt=%0d, required decodes=%b timeout=%b dest=%0d drop_cnt=%0d",
                             mon_e.nm, $time, mon_act, bus.wait_timeout, bus.dest_addr, bus.drop_cnt,
                             decodes(mon_e.ph), mon_e.to, mon_e.dest, mon_e.drop);
                end
            end
        end
    end

    // Stimulus: directed scenarios, random packets, drop-counter saturation.
    initial begin
        bus.pkt_valid     = 1'b0;
        bus.data_in       = '0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty    = '1;
        bus.soft_reset    = '0;

        step(0, 0, 8'h00, 0, 0, 0, 3'b111, 3'b000, P_DEC, "reset");
        step(0, 1, 8'h01, 0, 0, 0, 3'b111, 3'b000, P_DEC, "reset_hold");
        idle(1);

        pkt(8'h05, 4, -1, 0, 0, 0, 0, 0);
        idle(1);
        pkt(8'h03, 3, -1, 0, 0, 0, 0, 0);
        pkt(8'h0A, 2, 0, 0, 0, 0, 0, 0);
        pkt(8'h0A, 3, WAIT_MAX, 0, 0, 0, 0, 0);
        pkt(8'h04, 6, -1, 3, 5, 0, 0, 0);
        pkt(8'h01, 6, -1, 3, 5, 1, 0, 0);
        pkt(8'h09, 5, -1, 2, 2, 2, 0, 0);
        pkt(8'h0C, 5, -1, 0, 0, 0, 2, 0);
        pkt(8'h00, 5, -1, 0, 0, 0, 0, 2);

        header(8'h02, 1'b1, P_LFD, "hdr");
        step(1, 1, r8(), 0, 0, 0, r3(), 3'b000, P_LD, "lfd");
        step(1, 1, r8(), 0, 0, 0, r3(), 3'b000, P_LD, "ld");
        step(0, 1, r8(), 0, 0, 0, r3(), 3'b000, P_DEC, "reset_mid_packet");
        idle(2);

        for (int n = 0; n < 150; n++) begin
            int len, em, fp, fl, lm, cf, sp;
            len = int'($urandom_range(1, 6));
            em  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, WAIT_MAX)) : -1;
            fp  = (len > 1 && rb()) ? int'($urandom_range(1, len - 1)) : 0;
            fl  = int'($urandom_range(1, 4));
            lm  = int'($urandom_range(0, 2));
            cf  = rb() ? int'($urandom_range(1, 3)) : 0;
            sp  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, len)) : 0;
            idle(int'($urandom_range(0, 2)));
            pkt(r8(), len, em, fp, fl, lm, cf, sp);
        end

        for (int n = 0; n < 300; n++) pkt({r8() & 8'hFC} | 8'h03, 0, -1, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 0, r8(), 0, 0, 0, r3(), 3'b000, P_DEC, "reset_after_saturation");
        idle(1);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clock);
            #2;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
